seq_muldiv: RTL
===============

# seq_muldiv

- Parametrised, multi-cycle multiply/divide unit for the MIPS datapath, producing 2×WIDTH HI/LO results.
- Performs MULT, MULTU, DIV and DIVU with one bit per cycle (shift-add multiplier, restoring divider) under a valid/ready handshake.
- Sits beside the combinational ALU and feeds the HI/LO register path.
- Adds signed division, divide-by-zero reporting and mid-operation abort, none of which the single-cycle ALU provides.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A, B  in  WIDTH  operands (multiplicand/multiplier, dividend/divisor).
- kill  in  1  abort in-flight operation.
- out_valid  out  1  one-cycle pulse; result valid.
- ALU_Hi, ALU_Lo  out  WIDTH each  result; multiply: high/low product; divide: HI = remainder, LO = quotient.
- Zero  out  1  (ALU_Hi|ALU_Lo)==0, registered with result.
- err  out  1  divide by zero or unsupported op, registered with result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: transfer when in_valid & in_ready at a rising edge.
  - A, B and op are latched.
  - Signed ops convert operands to magnitudes and record result sign(s).
  - Normal next state is CALC with the iteration counter = WIDTH.
- Divide by zero (B==0, op DIV/DIVU): skip CALC and go directly to DONE.
  - Result: LO = all-ones, HI = A unchanged, err = 1.
- CALC: exactly WIDTH iterations, then FIX.
  - Multiply: 2W-bit accumulator, one multiplier bit per cycle.
  - Divide: one quotient bit per cycle, restoring.
  - Counter width is clog2(WIDTH)+1.
- FIX: apply signs, write ALU_Hi/ALU_Lo/Zero/err, then go to DONE.
  - MULT: negate the 2W product if the operand signs differ.
  - DIV: the quotient truncates toward zero; the remainder takes the dividend's sign.
  - Signed most-negative / −1: LO = most-negative (wraps), HI = 0, err = 0.
- DONE: out_valid = 1 for exactly one cycle, then IDLE.
- ALU_Hi, ALU_Lo, Zero and err hold their values until the next FIX or DONE write.
- kill:
  - High in CALC or FIX: go to IDLE next cycle, no out_valid, result registers unchanged.
  - In DONE: no effect.
  - In IDLE with in_valid: kill wins and nothing is accepted.
- in_valid outside IDLE is ignored; there is no queuing.
- Signed arithmetic: magnitudes use WIDTH+1 bits internally so that |most-negative| is exact.
- Multiply never sets err.

## Timing
- Accept at edge t → CALC cycles t+1..t+WIDTH → FIX t+WIDTH+1 → out_valid at t+WIDTH+2. WIDTH=32 gives 34 cycles.
- Divide-by-zero: out_valid in cycle t+1 (DONE). in_ready returns in cycle t+2.
- Normal ops: in_ready returns one cycle after DONE. Back-to-back issue interval is WIDTH+3.
- out_valid, ALU_Hi, ALU_Lo, Zero and err are all registered, with no combinational input-to-output path.
- in_ready is decoded from state.
- Reset values: state IDLE, in_ready 1, out_valid 0, ALU_Hi/ALU_Lo 0, Zero 1, err 0.
- Reset mid-operation discards the operation immediately, with no out_valid.
- Requests are ignored while reset is high.

## Configuration
- SEQ_MULDIV_DIV_EN defined: divider datapath is present and DIV/DIVU behave as above.
- Not defined: no divider logic.
  - DIV/DIVU are still accepted and go directly to DONE (out_valid at t+1).
  - Result: HI = LO = 0, Zero = 1, err = 1.
- MULT/MULTU are identical in both builds.

## Structure
- Package seq_muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum;
  - the default WIDTH constant.
- Sub-module sign_fix: parametrised conditional two's-complement negate (in, neg → out). Instantiated for operand magnitudes and for FIX-stage result correction.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → out_valid exactly 34 cycles after accept; HI = 0xFFFFFFFE, LO = 0x00000001, Zero = 0.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. MULT 0 × 0x1234 → Zero = 1.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0, err = 0.
- DIVU 10 / 0 → out_valid in cycle t+1, err = 1, LO = 0xFFFFFFFF, HI = 0x0000000A. Without SEQ_MULDIV_DIV_EN, DIVU 10 / 3 → HI = LO = 0, err = 1.
- kill in cycle t+10 of MULTU → no out_valid, in_ready high in t+11, HI/LO unchanged; next MULTU 6 × 7 → LO = 42.
- reset pulse mid-CALC → outputs at reset values, in_ready = 1; in_valid held during reset is not accepted.

Source files
------------

// File: rtl/seq_muldiv_pkg.sv
// rtl/seq_muldiv_pkg.sv - op encodings, FSM states and default width for seq_muldiv
package seq_muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/seq_muldiv_sign_fix.sv
// rtl/seq_muldiv_sign_fix.sv - conditional two's-complement negate
module sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg,
    output logic [W-1:0] out
);

    assign out = neg ? ((~in) + W'(1)) : in;

endmodule

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - one-bit-per-cycle MULT/MULTU/DIV/DIVU unit with HI/LO results
// Divider datapath present only when SEQ_MULDIV_DIV_EN is defined.
module seq_muldiv
    import seq_muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             kill,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_Hi,
    output logic [WIDTH-1:0] ALU_Lo,
    output logic             Zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   r_m;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu_hi;
    logic [WIDTH-1:0] r_alu_lo;
    logic             r_zero;
    logic             r_err;

    logic             w_accept;
    logic             w_direct;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH:0]   w_mag_a;
    logic [WIDTH:0]   w_mag_b;
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_unused;

    assign w_accept = in_valid & (r_state == S_IDLE) & ~kill;
    assign w_signed = op_is_signed(op);
    assign w_a_neg  = w_signed & A[WIDTH-1];
    assign w_b_neg  = w_signed & B[WIDTH-1];

    // One extra bit keeps |most-negative| exact after negation.
    sign_fix #(.W(WIDTH+1)) u_mag_a (.in({w_a_neg, A}), .neg(w_a_neg), .out(w_mag_a));
    sign_fix #(.W(WIDTH+1)) u_mag_b (.in({w_b_neg, B}), .neg(w_b_neg), .out(w_mag_b));

    sign_fix #(.W(2*WIDTH)) u_fix_prod (.in({r_hi, r_lo}), .neg(r_neg_res), .out(w_prod));

`ifdef SEQ_MULDIV_DIV_EN
    logic             w_b_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_b_zero   = (B == '0);
    assign w_direct   = op_is_div(op) & w_b_zero;
    assign w_shift    = {r_hi, r_lo[WIDTH-1]};
    assign w_trial    = {1'b0, w_shift} - {1'b0, r_m};
    assign w_ge       = ~w_trial[WIDTH+1];
    assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

    sign_fix #(.W(WIDTH)) u_fix_quo (.in(r_lo), .neg(r_neg_res), .out(w_quo_fix));
    sign_fix #(.W(WIDTH)) u_fix_rem (.in(r_hi), .neg(r_neg_rem), .out(w_rem_fix));

    assign w_res_hi = r_is_div ? w_rem_fix : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? w_quo_fix : w_prod[WIDTH-1:0];
    assign w_unused = ^{w_mag_a[WIDTH], w_trial[WIDTH]};
`else
    assign w_direct = op_is_div(op);
    assign w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = w_prod[WIDTH-1:0];
    assign w_unused = ^{w_mag_a[WIDTH], r_neg_rem, r_is_div};
`endif

    always_comb begin
        w_add     = {1'b0, r_hi} + (r_lo[0] ? r_m : '0);
        w_step_hi = w_add[WIDTH:1];
        w_step_lo = {w_add[0], r_lo[WIDTH-1:1]};
`ifdef SEQ_MULDIV_DIV_EN
        if (r_is_div) begin
            w_step_hi = w_rem_next;
            w_step_lo = {r_lo[WIDTH-2:0], w_ge};
        end
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_direct ? S_DONE : S_CALC;
            S_CALC: begin
                if (kill)                    w_next = S_IDLE;
                else if (r_cnt == CW'(1))    w_next = S_FIX;
            end
            S_FIX:  w_next = kill ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_m         <= '0;
            r_out_valid <= 1'b0;
            r_alu_hi    <= '0;
            r_alu_lo    <= '0;
            r_zero      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= CW'(WIDTH);
                        r_is_div  <= op_is_div(op);
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg & op_is_div(op);
                        r_hi      <= '0;
                        r_lo      <= w_mag_a[WIDTH-1:0];
                        r_m       <= w_mag_b;
                        if (w_direct) begin
`ifdef SEQ_MULDIV_DIV_EN
                            r_alu_hi <= A;
                            r_alu_lo <= '1;
                            r_zero   <= 1'b0;
`else
                            r_alu_hi <= '0;
                            r_alu_lo <= '0;
                            r_zero   <= 1'b1;
`endif
                            r_err    <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (!kill) begin
                        r_cnt <= r_cnt - CW'(1);
                        r_hi  <= w_step_hi;
                        r_lo  <= w_step_lo;
                    end
                end
                S_FIX: begin
                    if (!kill) begin
                        r_alu_hi <= w_res_hi;
                        r_alu_lo <= w_res_lo;
                        r_zero   <= ~|{w_res_hi, w_res_lo};
                        r_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign ALU_Hi    = r_alu_hi;
    assign ALU_Lo    = r_alu_lo;
    assign Zero      = r_zero;
    assign err       = r_err;

endmodule
